// File: rtl/mont_scheduler.sv
// Round-robin scheduler feeding a pipelined Montgomery reduction unit, with credit flow control and in-order responses.
// Optional feature: define MONT_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin group.
module mont_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_we_i,
  input  logic [63:0]                cfg_m_i,
  input  logic [63:0]                cfg_minv_i,
  input  logic [63:0]                cfg_m_bl_i,
  output logic                       cfg_busy_o,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*64-1:0]      req_x_i,
  output logic                       mont_start_o,
  output logic [63:0]                mont_x_o,
  output logic [63:0]                mont_m_o,
  output logic [63:0]                mont_minv_o,
  output logic [63:0]                mont_m_bl_o,
  input  logic                       mont_valid_i,
  input  logic [63:0]                mont_result_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [63:0]                rsp_data_o,
  output logic                       err_o
);
  localparam int unsigned DW = 64;
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned AW = $clog2(MAX_INFLIGHT);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_entry_t;

  state_e            state_q, state_d;
  logic [DW-1:0]     cfg_m_q, cfg_minv_q, cfg_mbl_q;
  logic              start_q;
  logic [DW-1:0]     x_q;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     tag_mem_q [MAX_INFLIGHT];
  rsp_entry_t        rsp_mem_q [MAX_INFLIGHT];
  logic [AW-1:0]     tag_wr_q, tag_rd_q, rsp_wr_q, rsp_rd_q;
  logic [CW-1:0]     tag_cnt_q, tag_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic              rsp_valid_q, busy_q, err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               hs, credit_ok, tag_pop, rsp_pop, cfg_load;
  rsp_entry_t         rsp_head;

  assign credit_ok = (SW'(tag_cnt_q) + SW'(rsp_cnt_q)) < SW'(MAX_INFLIGHT);

  // Rotating-priority search starting at ptr_q; the lowest offset that is valid wins.
  always_comb begin
    logic [NUM_REQ-1:0] cand;
    logic               any;
    int                 sum;
    cand    = req_valid_i;
    any     = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    sum     = 0;
`ifdef MONT_SCHED_PRIO_EN
    cand[0] = 1'b0;
`endif
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(ptr_q) + k;
      if (sum >= int'(NUM_REQ)) sum = sum - int'(NUM_REQ);
      if (cand[IW'(sum)]) begin
        gnt_idx = IW'(sum);
        any     = 1'b1;
      end
    end
`ifdef MONT_SCHED_PRIO_EN
    if (req_valid_i[0]) begin
      gnt_idx = '0;
      any     = 1'b1;
    end
`endif
    if (any && credit_ok && rst_ni) gnt[gnt_idx] = 1'b1;
  end

  assign hs       = |gnt;
  assign tag_pop  = mont_valid_i && (tag_cnt_q != '0);
  assign rsp_pop  = rsp_valid_q && rsp_ready_i;
  assign cfg_load = cfg_we_i && (state_q == IDLE);
  assign rsp_head = rsp_mem_q[rsp_rd_q];

  always_comb begin
    ptr_d     = ptr_q;
    tag_cnt_d = tag_cnt_q + CW'(hs) - CW'(tag_pop);
    rsp_cnt_d = rsp_cnt_q + CW'(tag_pop) - CW'(rsp_pop);
    err_d     = err_q | (cfg_we_i && (state_q != IDLE)) | (mont_valid_i && (tag_cnt_q == '0));
    if (hs) ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = RUN;
      RUN: begin
        if (!(|req_valid_i)) begin
          if (tag_cnt_q != '0 || rsp_cnt_q != '0) state_d = DRAIN;
          else                                    state_d = IDLE;
        end
      end
      DRAIN: begin
        if (hs)                                         state_d = RUN;
        else if (tag_cnt_q == '0 && rsp_cnt_q == '0)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_m_q     <= '0;
      cfg_minv_q  <= '0;
      cfg_mbl_q   <= '0;
      start_q     <= 1'b0;
      x_q         <= '0;
      ptr_q       <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      tag_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
        tag_mem_q[i] <= '0;
        rsp_mem_q[i] <= '0;
      end
    end else begin
      if (cfg_load) begin
        cfg_m_q    <= cfg_m_i;
        cfg_minv_q <= cfg_minv_i;
        cfg_mbl_q  <= cfg_m_bl_i;
      end
      start_q <= hs;
      if (hs) begin
        x_q                 <= req_x_i[DW*32'(gnt_idx) +: DW];
        tag_mem_q[tag_wr_q] <= gnt_idx;
        tag_wr_q            <= tag_wr_q + AW'(1);
      end
      // Results arrive in issue order, so the oldest tag names the requester.
      if (tag_pop) begin
        rsp_mem_q[rsp_wr_q] <= '{id: tag_mem_q[tag_rd_q], data: mont_result_i};
        rsp_wr_q            <= rsp_wr_q + AW'(1);
        tag_rd_q            <= tag_rd_q + AW'(1);
      end
      if (rsp_pop) rsp_rd_q <= rsp_rd_q + AW'(1);
      ptr_q       <= ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_valid_q <= (rsp_cnt_d != '0);
      busy_q      <= (tag_cnt_d != '0) || (rsp_cnt_d != '0);
      err_q       <= err_d;
    end
  end

  assign req_ready_o  = gnt;
  assign mont_start_o = start_q;
  assign mont_x_o     = x_q;
  assign mont_m_o     = cfg_m_q;
  assign mont_minv_o  = cfg_minv_q;
  assign mont_m_bl_o  = cfg_mbl_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_head.id;
  assign rsp_data_o   = rsp_head.data;
  assign cfg_busy_o   = busy_q;
  assign err_o        = err_q;
endmodule
